// File: rtl/llsc_monitor_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : llsc_monitor_ctrl_pkg
// Purpose  : Shared encodings for the LL/SC reservation controller.
//            - Memory-operation codes seen on the MEM-stage request port.
//            - FSM state codes.
//            - Reset polarity constant.
// Revision : 1.0 - initial release
// ============================================================================
package llsc_monitor_ctrl_pkg;

    // MEM-stage request opcode
    typedef enum logic [1:0] {
        MEM_OP_NONE = 2'b00,
        MEM_OP_LL   = 2'b01,
        MEM_OP_SC   = 2'b10,
        MEM_OP_ST   = 2'b11
    } mem_op_e;

    // Reservation controller FSM state
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RESV    = 2'b01,
        ST_SC_WAIT = 2'b10
    } state_e;

    // Level of rst that holds the design in reset (active-low)
    localparam logic RST_ENABLE = 1'b0;

endpackage : llsc_monitor_ctrl_pkg
`default_nettype wire

// File: rtl/llsc_monitor_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : llsc_monitor_ctrl_if
// Purpose  : Bundles the MEM-stage request, snoop, LLbit register and
//            reservation/result signals of the LL/SC controller.
// Modports : master - pipeline/environment side (drives requests, snoops,
//                     current LLbit value)
//            slave  - the controller
// Revision : 1.0 - initial release
// ============================================================================
interface llsc_monitor_ctrl_if #(
    parameter int ADDR_W = 32
);
    import llsc_monitor_ctrl_pkg::*;

    logic              mem_valid_i;
    mem_op_e           mem_op_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic              mem_ready_o;
    logic              snoop_valid_i;
    logic [ADDR_W-1:0] snoop_addr_i;
    logic              llbit_q_i;
    logic              llbit_we_o;
    logic              llbit_d_o;
    logic              llbit_flush_o;
    logic              sc_valid_o;
    logic              sc_success_o;
    logic              resv_valid_o;
    logic [ADDR_W-1:0] resv_addr_o;

    modport master (
        output mem_valid_i, mem_op_i, mem_addr_i, snoop_valid_i, snoop_addr_i,
               llbit_q_i,
        input  mem_ready_o, llbit_we_o, llbit_d_o, llbit_flush_o, sc_valid_o,
               sc_success_o, resv_valid_o, resv_addr_o
    );

    modport slave (
        input  mem_valid_i, mem_op_i, mem_addr_i, snoop_valid_i, snoop_addr_i,
               llbit_q_i,
        output mem_ready_o, llbit_we_o, llbit_d_o, llbit_flush_o, sc_valid_o,
               sc_success_o, resv_valid_o, resv_addr_o
    );

endinterface : llsc_monitor_ctrl_if
`default_nettype wire

// File: rtl/llsc_monitor_ctrl_resv_timer.sv
`default_nettype none
// ============================================================================
// Module   : llsc_resv_timer
// Purpose  : Loadable saturating down-counter bounding reservation lifetime.
// Ports    : clk      - clock, rising edge
//            rst      - asynchronous reset, active-low
//            load     - load counter with load_val (wins over run)
//            load_val - reload value; 0 means the timer never expires
//            run      - decrement enable (reservation held)
//            expire   - counter is at 1 while running: last cycle of lifetime
// Revision : 1.0 - initial release
// ============================================================================
module llsc_resv_timer
    import llsc_monitor_ctrl_pkg::*;
#(
    parameter int TMO_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [TMO_W-1:0] load_val,
    input  wire logic             run,
    output logic                  expire
);

    localparam logic [TMO_W-1:0] c_one = TMO_W'(1);

    logic [TMO_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (run && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    // A zero load value parks the counter at 0, so expiry never fires.
    assign expire = run && (r_count == c_one);

endmodule : llsc_resv_timer
`default_nettype wire

// File: rtl/llsc_monitor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : llsc_monitor_ctrl
// Purpose  : LL/SC reservation controller beside the MEM stage. Holds the
//            reserved granule address and lifetime timer, resolves SC in one
//            extra cycle, drives the LLbit register write/flush port and
//            breaks the reservation on matching snooped or own plain stores.
// Ports    : clk   - clock, rising edge
//            rst   - asynchronous reset, active-low
//            flush - exception/ERET flush (highest priority)
//            bus   - llsc_monitor_ctrl_if.slave: MEM request/ready, snoop,
//                    LLbit q/we/d/flush, SC result, reservation status
// Revision : 1.0 - initial release
// ============================================================================
module llsc_monitor_ctrl
    import llsc_monitor_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int GRAN_LSB = 2,
    parameter int TMO_W    = 8,
    parameter int TMO_VAL  = 200
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          flush,
    llsc_monitor_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_gran_mask = {ADDR_W{1'b1}} << GRAN_LSB;
    localparam logic [TMO_W-1:0]  c_tmo_load  = TMO_W'(TMO_VAL);

    state_e            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_resv_addr, w_resv_addr_nxt;
    logic              r_sc_result, w_sc_result_nxt;
    logic              r_fwd_valid, r_fwd_d;
    logic              w_we, w_d, w_ready, w_sc_valid, w_timer_load, w_expire;

    logic              w_req_ll, w_req_sc, w_req_st;
    logic [ADDR_W-1:0] w_req_gaddr, w_snp_gaddr;
    logic              w_snoop_hit_req, w_snoop_hit_resv, w_addr_hit_resv;
    logic              w_llbit_eff;

    assign w_req_ll = bus.mem_valid_i && (bus.mem_op_i == MEM_OP_LL);
    assign w_req_sc = bus.mem_valid_i && (bus.mem_op_i == MEM_OP_SC);
    assign w_req_st = bus.mem_valid_i && (bus.mem_op_i == MEM_OP_ST);

    assign w_req_gaddr      = bus.mem_addr_i & c_gran_mask;
    assign w_snp_gaddr      = bus.snoop_addr_i & c_gran_mask;
    assign w_snoop_hit_req  = bus.snoop_valid_i && (w_snp_gaddr == w_req_gaddr);
    assign w_snoop_hit_resv = bus.snoop_valid_i && (w_snp_gaddr == r_resv_addr);
    assign w_addr_hit_resv  = (w_req_gaddr == r_resv_addr);

    // The LLbit register lags our write by a cycle; an SC right after LL
    // must see the value we just wrote rather than the stale register.
    assign w_llbit_eff = r_fwd_valid ? r_fwd_d : bus.llbit_q_i;

    llsc_resv_timer #(
        .TMO_W (TMO_W)
    ) u_resv_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_timer_load),
        .load_val (c_tmo_load),
        .run      (r_state == ST_RESV),
        .expire   (w_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_state     <= ST_IDLE;
            r_resv_addr <= '0;
            r_sc_result <= 1'b0;
            r_fwd_valid <= 1'b0;
            r_fwd_d     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_resv_addr <= w_resv_addr_nxt;
            r_sc_result <= w_sc_result_nxt;
            r_fwd_valid <= w_we;
            r_fwd_d     <= w_d;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_resv_addr_nxt = r_resv_addr;
        w_sc_result_nxt = r_sc_result;
        w_we            = 1'b0;
        w_d             = 1'b0;
        w_ready         = 1'b1;
        w_sc_valid      = 1'b0;
        w_timer_load    = 1'b0;

        if (flush) begin
            // Flush kills everything, including a pending SC result.
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_RESV: begin
                    if (w_req_ll) begin
                        w_we = 1'b1;
                        if (w_snoop_hit_req) begin
                            // Racing external store: never establish.
                            w_d         = 1'b0;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_d             = 1'b1;
                            w_state_nxt     = ST_RESV;
                            w_resv_addr_nxt = w_req_gaddr;
                            w_timer_load    = 1'b1;
                        end
                    end else if (w_req_sc) begin
                        w_ready         = 1'b0;
                        w_state_nxt     = ST_SC_WAIT;
                        w_sc_result_nxt = (r_state == ST_RESV) && w_addr_hit_resv &&
                                          w_llbit_eff && !w_snoop_hit_resv;
                    end else if ((r_state == ST_RESV) &&
                                 (w_snoop_hit_resv || (w_req_st && w_addr_hit_resv) ||
                                  w_expire)) begin
                        w_we        = 1'b1;
                        w_d         = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_SC_WAIT: begin
                    w_sc_valid  = 1'b1;
                    w_we        = 1'b1;
                    w_d         = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_ready_o   = w_ready;
    assign bus.llbit_we_o    = w_we;
    assign bus.llbit_d_o     = w_d;
    assign bus.llbit_flush_o = flush;
    assign bus.sc_valid_o    = w_sc_valid;
    assign bus.sc_success_o  = w_sc_valid && r_sc_result;
    assign bus.resv_valid_o  = (r_state == ST_RESV);
    assign bus.resv_addr_o   = r_resv_addr;

endmodule : llsc_monitor_ctrl
`default_nettype wire
